// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment scanner with inter-digit blanking,
// a per-frame byte latch and an optional blink that gates whole frames.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       blink_en,
  output logic [1:0] sel,
  output logic [6:0] data_out,
  output logic       frame_tick
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam bit          HAS_BLANK  = (BLANK_CYC != 0);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = HAS_BLANK ? CW'(BLANK_CYC - 1) : '0;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    SCAN_D0,
    BLANK0,
    SCAN_D1,
    BLANK1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]    shadow_q, shadow_d;
  logic          blink_phase_q, blink_phase_d;
  logic          frame_phase_q, frame_phase_d;
  logic [1:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick_q, tick_d;
  logic          state_chg;
  logic          enter_d0;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] raw;
    case (nib)
      4'h0:    raw = 7'h3F;
      4'h1:    raw = 7'h06;
      4'h2:    raw = 7'h5B;
      4'h3:    raw = 7'h4F;
      4'h4:    raw = 7'h66;
      4'h5:    raw = 7'h6D;
      4'h6:    raw = 7'h7D;
      4'h7:    raw = 7'h07;
      4'h8:    raw = 7'h7F;
      4'h9:    raw = 7'h6F;
      4'hA:    raw = 7'h77;
      4'hB:    raw = 7'h7C;
      4'hC:    raw = 7'h39;
      4'hD:    raw = 7'h5E;
      4'hE:    raw = 7'h79;
      default: raw = 7'h71;
    endcase
    return SEG_ACTIVE_LOW ? ~raw : raw;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      SCAN_D0: if (cnt_q == SCAN_LAST) begin
        cnt_d   = '0;
        state_d = HAS_BLANK ? BLANK0 : SCAN_D1;
      end
      BLANK0: if (cnt_q == BLANK_LAST) begin
        cnt_d   = '0;
        state_d = SCAN_D1;
      end
      SCAN_D1: if (cnt_q == SCAN_LAST) begin
        cnt_d   = '0;
        state_d = HAS_BLANK ? BLANK1 : SCAN_D0;
      end
      default: if (cnt_q == BLANK_LAST) begin
        cnt_d   = '0;
        state_d = SCAN_D0;
      end
    endcase
  end

  assign state_chg = (state_d != state_q);
  assign enter_d0  = state_chg && (state_d == SCAN_D0);

  // Outputs are computed from the state being entered and then held, so the
  // registered pins change on the same edge as the state register.
  // frame_phase holds the phase seen at frame start so both digits agree.
  always_comb begin
    shadow_d      = shadow_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_phase_d = frame_phase_q;
    sel_d         = sel_q;
    seg_d         = seg_q;
    tick_d        = 1'b0;
    if (enter_d0) begin
      shadow_d      = data_in;
      tick_d        = 1'b1;
      frame_phase_d = blink_phase_q;
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    if (state_chg) begin
      case (state_d)
        SCAN_D0: begin
          sel_d = 2'b01;
          seg_d = (blink_en && blink_phase_q) ? SEG_OFF : hex_to_seg(data_in[3:0]);
        end
        SCAN_D1: begin
          sel_d = 2'b10;
          seg_d = (blink_en && frame_phase_q) ? SEG_OFF : hex_to_seg(shadow_q[7:4]);
        end
        default: begin
          sel_d = 2'b00;
          seg_d = SEG_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BLANK1;
      cnt_q         <= '0;
      frame_cnt_q   <= '0;
      shadow_q      <= '0;
      blink_phase_q <= 1'b0;
      frame_phase_q <= 1'b0;
      sel_q         <= 2'b00;
      seg_q         <= SEG_OFF;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      shadow_q      <= shadow_d;
      blink_phase_q <= blink_phase_d;
      frame_phase_q <= frame_phase_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
      tick_q        <= tick_d;
    end
  end

  assign sel        = sel_q;
  assign data_out   = seg_q;
  assign frame_tick = tick_q;

endmodule
